// File: rtl/stopwatch_pkg.sv
// Shared encodings for the stopwatch control front-end: FSM states, button
// indices and the default debounce length.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_e;

   localparam int unsigned START    = 0;
   localparam int unsigned STOP     = 1;
   localparam int unsigned CLEAR    = 2;
   localparam int unsigned LAP      = 3;
   localparam int unsigned NUM_BTNS = 4;

   localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 100000;

endpackage

// File: rtl/stopwatch_ctrl_btn_debounce.sv
// One button channel: 2-FF synchronizer, stable-level debounce counter and a
// one-cycle press pulse on each accepted 0->1 transition.
module btn_debounce
   import stopwatch_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_raw,
   output logic press_o
);

   localparam int unsigned CNT_BITS = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(DEBOUNCE_CYCLES - 1);

   logic                sync1_q, sync2_q;
   logic                level_q, level_d;
   logic                level_prev_q;
   logic [CNT_BITS-1:0] cnt_q, cnt_d;
   logic [1:0]          fill_q, fill_d;
   logic                armed_q, armed_d;
   logic                press_q, press_d;

   // Pulses stay disarmed until a released level is seen after reset, so a
   // button held through reset cannot fire until it is let go and re-pressed.
   always_comb begin
      cnt_d   = cnt_q;
      level_d = level_q;
      if (sync2_q == level_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         cnt_d   = '0;
         level_d = sync2_q;
      end else begin
         cnt_d = cnt_q + CNT_BITS'(1);
      end
      fill_d  = (fill_q == 2'd2) ? fill_q : fill_q + 2'd1;
      armed_d = armed_q | ((fill_q == 2'd2) & ~sync2_q);
      press_d = armed_q & level_q & ~level_prev_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q      <= 1'b0;
         sync2_q      <= 1'b0;
         level_q      <= 1'b0;
         level_prev_q <= 1'b0;
         cnt_q        <= '0;
         fill_q       <= 2'd0;
         armed_q      <= 1'b0;
         press_q      <= 1'b0;
      end else begin
         sync1_q      <= btn_raw;
         sync2_q      <= sync1_q;
         level_q      <= level_d;
         level_prev_q <= level_q;
         cnt_q        <= cnt_d;
         fill_q       <= fill_d;
         armed_q      <= armed_d;
         press_q      <= press_d;
      end
   end

   assign press_o = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch start/stop/clear/lap controller with debounced buttons.
// Optional auto-stop at MAX_COUNT is enabled by defining STOPWATCH_AUTO_STOP_EN.
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
   parameter int unsigned CNT_W           = 10,
   parameter int unsigned MAX_COUNT       = 999
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             btn_start,
   input  logic             btn_stop,
   input  logic             btn_clear,
   input  logic             btn_lap,
   input  logic [CNT_W-1:0] count_value,
   output logic             count_enable,
   output logic             count_clr,
   output logic [CNT_W-1:0] display_value,
   output logic             lap_active,
   output logic [1:0]       state_o,
   output logic             max_hit
);

   if (MAX_COUNT >= (64'd1 << CNT_W)) begin : g_bad_max_count
      $error("stopwatch_ctrl: MAX_COUNT does not fit in CNT_W bits");
   end

   logic [NUM_BTNS-1:0] btn_raw;
   logic [NUM_BTNS-1:0] press;

   assign btn_raw = {btn_lap, btn_clear, btn_stop, btn_start};

   for (genvar g = 0; g < NUM_BTNS; g++) begin : g_btn
      btn_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_debounce (
         .clk     (clk),
         .rst_n   (rst_n),
         .btn_raw (btn_raw[g]),
         .press_o (press[g])
      );
   end

   state_e           state_q, state_d;
   logic             count_clr_q, count_clr_d;
   logic             lap_active_q, lap_active_d;
   logic [CNT_W-1:0] snapshot_q, snapshot_d;
`ifdef STOPWATCH_AUTO_STOP_EN
   logic             max_hit_q, max_hit_d;
   logic             at_max;

   assign at_max = (count_value == CNT_W'(MAX_COUNT));
`endif

   // Each state resolves simultaneous presses by testing the winning button first.
   always_comb begin
      state_d      = state_q;
      count_clr_d  = 1'b0;
      lap_active_d = lap_active_q;
      snapshot_d   = snapshot_q;
`ifdef STOPWATCH_AUTO_STOP_EN
      max_hit_d    = max_hit_q;
`endif
      case (state_q)
         IDLE: begin
            if (press[START]) begin
               state_d = RUN;
            end else if (press[CLEAR]) begin
               count_clr_d = 1'b1;
            end
         end
         RUN: begin
`ifdef STOPWATCH_AUTO_STOP_EN
            if (at_max) begin
               state_d   = PAUSE;
               max_hit_d = 1'b1;
            end else
`endif
            if (press[STOP]) begin
               state_d = PAUSE;
            end else if (press[LAP]) begin
               if (lap_active_q) begin
                  lap_active_d = 1'b0;
               end else begin
                  lap_active_d = 1'b1;
                  snapshot_d   = count_value;
               end
            end
         end
         PAUSE: begin
            if (press[CLEAR]) begin
               state_d      = IDLE;
               count_clr_d  = 1'b1;
               lap_active_d = 1'b0;
            end else if (press[START]) begin
               state_d = RUN;
            end else if (press[LAP] && lap_active_q) begin
               lap_active_d = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
`ifdef STOPWATCH_AUTO_STOP_EN
      if ((state_d == IDLE) && (state_q != IDLE)) begin
         max_hit_d = 1'b0;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         count_clr_q  <= 1'b0;
         lap_active_q <= 1'b0;
         snapshot_q   <= '0;
`ifdef STOPWATCH_AUTO_STOP_EN
         max_hit_q    <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         count_clr_q  <= count_clr_d;
         lap_active_q <= lap_active_d;
         snapshot_q   <= snapshot_d;
`ifdef STOPWATCH_AUTO_STOP_EN
         max_hit_q    <= max_hit_d;
`endif
      end
   end

   assign count_enable  = (state_q == RUN);
   assign count_clr     = count_clr_q;
   assign lap_active    = lap_active_q;
   assign display_value = lap_active_q ? snapshot_q : count_value;
   assign state_o       = state_q;
`ifdef STOPWATCH_AUTO_STOP_EN
   assign max_hit       = max_hit_q;
`else
   assign max_hit       = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed testbench for stopwatch_ctrl with a short debounce length.
// Works in both builds; the auto-stop scenario runs when STOPWATCH_AUTO_STOP_EN is defined.
module tb_stopwatch_ctrl;

   localparam int unsigned DEB  = 4;
   localparam int unsigned CW   = 10;
   localparam int unsigned MAXC = 20;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          btn_start = 1'b0;
   logic          btn_stop = 1'b0;
   logic          btn_clear = 1'b0;
   logic          btn_lap = 1'b0;
   logic [CW-1:0] count_value = '0;
   logic          count_enable;
   logic          count_clr;
   logic [CW-1:0] display_value;
   logic          lap_active;
   logic [1:0]    state_o;
   logic          max_hit;

   int check_count = 0;
   int pass_count  = 0;

   // Button masks: bit0 start, bit1 stop, bit2 clear, bit3 lap.
   typedef struct {
      string         name;
      logic [3:0]    mask;
      logic [CW-1:0] cval;
      logic [1:0]    exp_state;
      logic          exp_en;
      logic          exp_clr;
   } vec_t;

   vec_t vecs[11];

   stopwatch_ctrl #(
      .DEBOUNCE_CYCLES (DEB),
      .CNT_W           (CW),
      .MAX_COUNT       (MAXC)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .btn_start     (btn_start),
      .btn_stop      (btn_stop),
      .btn_clear     (btn_clear),
      .btn_lap       (btn_lap),
      .count_value   (count_value),
      .count_enable  (count_enable),
      .count_clr     (count_clr),
      .display_value (display_value),
      .lap_active    (lap_active),
      .state_o       (state_o),
      .max_hit       (max_hit)
   );

   always #5 clk = ~clk;

   // Everything in the bench happens 1 ns after a rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
      check_count++;
      if (actual === required) pass_count++;
      else $display("[TB] FAIL %s: actual %0d required %0d", name, actual, required);
   endtask

   task automatic setButtons(input logic [3:0] mask);
      {btn_lap, btn_clear, btn_stop, btn_start} = mask;
   endtask

   // Raise the buttons and wait until the FSM has acted on the press
   // (2 sync + DEB debounce + 1 pulse cycle, state updates on the next edge).
   task automatic applyStimulus(input logic [3:0] mask);
      setButtons(mask);
      repeat (7) tick();
      checkOutput("clr_before_edge", count_clr, 1'b0);
      tick();
   endtask

   task automatic releaseButtons();
      setButtons(4'b0000);
      repeat (8) tick();
   endtask

   // Watchdog so a stuck run still ends with a report.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: actual timeout required finish");
      $fatal(1);
   end

   initial begin
      int left_idle;
      int latency;

      vecs = '{
         '{"stop_in_idle",   4'b0010, 10'd3, 2'd0, 1'b0, 1'b0},
         '{"lap_in_idle",    4'b1000, 10'd3, 2'd0, 1'b0, 1'b0},
         '{"clear_in_idle",  4'b0100, 10'd3, 2'd0, 1'b0, 1'b1},
         '{"start_clr_idle", 4'b0101, 10'd4, 2'd1, 1'b1, 1'b0},
         '{"start_in_run",   4'b0001, 10'd5, 2'd1, 1'b1, 1'b0},
         '{"clear_in_run",   4'b0100, 10'd6, 2'd1, 1'b1, 1'b0},
         '{"stop_in_run",    4'b0010, 10'd7, 2'd2, 1'b0, 1'b0},
         '{"lap_pause_free", 4'b1000, 10'd7, 2'd2, 1'b0, 1'b0},
         '{"start_in_pause", 4'b0001, 10'd8, 2'd1, 1'b1, 1'b0},
         '{"stop_again",     4'b0010, 10'd9, 2'd2, 1'b0, 1'b0},
         '{"clear_in_pause", 4'b0100, 10'd9, 2'd0, 1'b0, 1'b1}
      };

      // Reset values while rst_n is held low.
      count_value = 10'd5;
      #1;
      checkOutput("rst_state", state_o, 2'd0);
      checkOutput("rst_enable", count_enable, 1'b0);
      checkOutput("rst_clr", count_clr, 1'b0);
      checkOutput("rst_lap", lap_active, 1'b0);
      checkOutput("rst_max_hit", max_hit, 1'b0);
      checkOutput("rst_display", display_value, 10'd5);
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (4) tick();

      // Table-driven single and simultaneous presses.
      for (int i = 0; i < 11; i++) begin
         count_value = vecs[i].cval;
         applyStimulus(vecs[i].mask);
         checkOutput({vecs[i].name, "_state"}, state_o, vecs[i].exp_state);
         checkOutput({vecs[i].name, "_enable"}, count_enable, vecs[i].exp_en);
         checkOutput({vecs[i].name, "_clr"}, count_clr, vecs[i].exp_clr);
         checkOutput({vecs[i].name, "_display"}, display_value, vecs[i].cval);
         checkOutput({vecs[i].name, "_lap"}, lap_active, 1'b0);
         checkOutput({vecs[i].name, "_max_hit"}, max_hit, 1'b0);
         setButtons(4'b0000);
         tick();
         checkOutput({vecs[i].name, "_clr_after"}, count_clr, 1'b0);
         repeat (7) tick();
      end

      // Bounce rejection on start, then a clean hold.
      left_idle = 0;
      for (int i = 0; i < 20; i++) begin
         btn_start = ((i / 2) % 2) == 0;
         tick();
         if (state_o != 2'd0) left_idle++;
      end
      checkOutput("bounce_no_press", left_idle, 0);
      btn_start = 1'b1;
      latency = -1;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (state_o == 2'd1) begin
            latency = i;
            break;
         end
      end
      checkOutput("bounce_latency", latency, 8);
      checkOutput("bounce_enable", count_enable, 1'b1);
      releaseButtons();

      // Lap freeze at 37 while the count ramps to 60.
      count_value = 10'd30;
      btn_lap = 1'b1;
      for (int n = 1; n <= 30; n++) begin
         tick();
         if (n == 7) checkOutput("lap_not_yet", lap_active, 1'b0);
         count_value = CW'(30 + n);
         if (n == 8) begin
            btn_lap = 1'b0;
            #1;
            checkOutput("lap_active_set", lap_active, 1'b1);
            checkOutput("lap_snapshot", display_value, 10'd37);
         end
      end
      #1;
      checkOutput("lap_hold_at_60", display_value, 10'd37);
      checkOutput("lap_state_run", state_o, 2'd1);
      applyStimulus(4'b1000);
      checkOutput("lap_release", lap_active, 1'b0);
      releaseButtons();
      count_value = 10'd61;
      #1;
      checkOutput("lap_live_again", display_value, 10'd61);
      applyStimulus(4'b0010);
      releaseButtons();
      applyStimulus(4'b0100);
      checkOutput("lap_back_idle", state_o, 2'd0);
      releaseButtons();

      // Simultaneous presses: stop beats lap in RUN, clear beats start in PAUSE.
      applyStimulus(4'b0001);
      releaseButtons();
      count_value = 10'd12;
      applyStimulus(4'b1000);
      checkOutput("sim_lap_frozen", lap_active, 1'b1);
      releaseButtons();
      count_value = 10'd13;
      applyStimulus(4'b1010);
      checkOutput("sim_stop_lap_state", state_o, 2'd2);
      checkOutput("sim_stop_lap_lap", lap_active, 1'b1);
      checkOutput("sim_stop_lap_disp", display_value, 10'd12);
      releaseButtons();
      applyStimulus(4'b0101);
      checkOutput("sim_clr_start_state", state_o, 2'd0);
      checkOutput("sim_clr_start_clr", count_clr, 1'b1);
      checkOutput("sim_clr_start_lap", lap_active, 1'b0);
      setButtons(4'b0000);
      tick();
      checkOutput("sim_clr_start_clr_after", count_clr, 1'b0);
      repeat (7) tick();

      // Lap while frozen in PAUSE releases the freeze.
      applyStimulus(4'b0001);
      releaseButtons();
      applyStimulus(4'b1000);
      releaseButtons();
      applyStimulus(4'b0010);
      releaseButtons();
      count_value = 10'd14;
      applyStimulus(4'b1000);
      checkOutput("pause_lap_state", state_o, 2'd2);
      checkOutput("pause_lap_release", lap_active, 1'b0);
      releaseButtons();
      applyStimulus(4'b0100);
      releaseButtons();

      // Async reset in RUN with the lap frozen, start held through reset.
      applyStimulus(4'b0001);
      releaseButtons();
      count_value = 10'd15;
      applyStimulus(4'b1000);
      releaseButtons();
      count_value = 10'd16;
      btn_start = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async_rst_state", state_o, 2'd0);
      checkOutput("async_rst_enable", count_enable, 1'b0);
      checkOutput("async_rst_lap", lap_active, 1'b0);
      checkOutput("async_rst_clr", count_clr, 1'b0);
      checkOutput("async_rst_display", display_value, 10'd16);
      repeat (2) tick();
      rst_n = 1'b1;
      left_idle = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (state_o != 2'd0) left_idle++;
      end
      checkOutput("held_through_reset", left_idle, 0);
      releaseButtons();
      applyStimulus(4'b0001);
      checkOutput("repress_after_reset", state_o, 2'd1);
      releaseButtons();

      // Reaching MAX_COUNT in RUN.
      count_value = 10'd19;
      tick();
      checkOutput("near_max_state", state_o, 2'd1);
      count_value = 10'd20;
      tick();
`ifdef STOPWATCH_AUTO_STOP_EN
      checkOutput("auto_stop_state", state_o, 2'd2);
      checkOutput("auto_stop_max_hit", max_hit, 1'b1);
      count_value = 10'd0;
      applyStimulus(4'b0100);
      checkOutput("auto_clear_state", state_o, 2'd0);
      checkOutput("auto_clear_max_hit", max_hit, 1'b0);
      releaseButtons();
`else
      tick();
      checkOutput("no_auto_stop_state", state_o, 2'd1);
      checkOutput("no_auto_stop_max_hit", max_hit, 1'b0);
      applyStimulus(4'b0010);
      releaseButtons();
      applyStimulus(4'b0100);
      checkOutput("final_idle", state_o, 2'd0);
      releaseButtons();
`endif

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
